// File: rtl/eth_frame_dropper.sv
// AXI4-Stream frame filter: discards whole frames whose first beat arrives while the
// rear FIFO is almost full, otherwise forwards them through a one-deep register slice.
module eth_frame_dropper #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          drop_enable,
  input  logic                          fifo_is_almost_full,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [1:0]                    o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                          r_state;
  logic                            r_m_valid;
  logic [C_AXIS_TDATA_WIDTH-1:0]   r_m_data;
  logic [C_AXIS_TKEEP_WIDTH-1:0]   r_m_keep;
  logic                            r_m_last;

  logic w_out_ready;
  logic w_drop_now;
  logic w_s_ready;
  logic w_s_hs;
  logic w_load;

  // Handshakes: a beat transfers on a rising edge where valid && ready; a source holds
  // its beat stable until then, and ready may depend combinationally on the sink side.
  assign w_out_ready = !r_m_valid || m_axis_tready;
  assign w_drop_now  = drop_enable && fifo_is_almost_full;

  always_comb begin
    w_s_ready = w_out_ready;
    case (r_state)
      IDLE:    w_s_ready = w_drop_now ? 1'b1 : w_out_ready;
      PASS:    w_s_ready = w_out_ready;
      DROP:    w_s_ready = 1'b1;
      default: w_s_ready = w_out_ready;
    endcase
  end

  assign w_s_hs = s_axis_tvalid && w_s_ready;
  // Only the first beat of a frame looks at the flag; later beats follow the frame's fate.
  assign w_load = w_s_hs && ((r_state == PASS) || ((r_state == IDLE) && !w_drop_now));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      if (w_s_hs) begin
        case (r_state)
          IDLE: begin
            if (s_axis_tlast) r_state <= IDLE;
            else if (w_drop_now) r_state <= DROP;
            else r_state <= PASS;
          end
          PASS:    if (s_axis_tlast) r_state <= IDLE;
          DROP:    if (s_axis_tlast) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end

      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_axis_tdata;
        r_m_keep  <= s_axis_tkeep;
        r_m_last  <= s_axis_tlast;
      end else if (m_axis_tready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tlast  = r_m_last;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_eth_frame_dropper.sv
// Bench for eth_frame_dropper: vector table, directed frame sequences and randomized
// traffic checked by a frame-level reference model and an expected-beat queue.
module tb_eth_frame_dropper;

  localparam int DW = 8;
  localparam int KW = DW / 8;
  localparam int BW = DW + KW + 1;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          drop_enable = 1'b0;
  logic          fifo_is_almost_full = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [1:0]    dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  bit m_mode   = 1'b0;

  logic [BW-1:0] exp_q[$];
  bit            mdl_in_frame = 1'b0;
  bit            mdl_dropping = 1'b0;
  bit            prev_stall   = 1'b0;
  logic [BW-1:0] prev_beat    = '0;

  eth_frame_dropper #(.C_AXIS_TDATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .drop_enable         (drop_enable),
    .fifo_is_almost_full (fifo_is_almost_full),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tkeep        (s_axis_tkeep),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tlast        (s_axis_tlast),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tkeep        (m_axis_tkeep),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .o_dbg_state         (dbg_state)
  );

  // clock / reset-independent watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_axis_tready = m_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // scoreboard / reference model, sampled mid-cycle when everything is settled
  always @(negedge clk) begin
    logic [BW-1:0] out_beat;
    logic [BW-1:0] in_beat;
    logic [BW-1:0] exp_beat;
    bit            drop_now;
    bit            exp_ready;
    if (!rstn) begin
      exp_q.delete();
      mdl_in_frame = 1'b0;
      mdl_dropping = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      drop_now  = drop_enable && fifo_is_almost_full;
      exp_ready = (mdl_in_frame && mdl_dropping) || (!mdl_in_frame && drop_now) ||
                  !m_axis_tvalid || m_axis_tready;
      check("s_tready", 32'(s_axis_tready), 32'(exp_ready));

      out_beat = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (prev_stall) begin
        check("hold_valid", 32'(m_axis_tvalid), 32'd1);
        check("hold_beat", 32'(out_beat), 32'(prev_beat));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = out_beat;

      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_beat), 32'hFFFF_FFFF);
        end else begin
          exp_beat = exp_q.pop_front();
          check("out_beat", 32'(out_beat), 32'(exp_beat));
        end
      end

      if (s_axis_tvalid && s_axis_tready) begin
        in_beat = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (!mdl_in_frame) begin
          mdl_in_frame = 1'b1;
          mdl_dropping = drop_now;
        end
        if (!mdl_dropping) exp_q.push_back(in_beat);
        if (s_axis_tlast) mdl_in_frame = 1'b0;
      end
    end
  end

  // expect_mode: 0 = no directed expectation, 1 = frame must pass, 2 = frame must drop
  task automatic send_frame(input int n, input int flag_beat, input bit de,
                            input int flag_pct, input bit gaps, input int expect_mode);
    int  waits;
    bit  hs;
    drop_enable = de;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid       = 1'b0;
        fifo_is_almost_full = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      s_axis_tdata        = DW'($urandom);
      s_axis_tkeep        = KW'($urandom);
      s_axis_tlast        = (i == n - 1);
      s_axis_tvalid       = 1'b1;
      fifo_is_almost_full = (i == flag_beat) || ($urandom_range(0, 99) < flag_pct);
      waits = 0;
      forever begin
        @(negedge clk);
        hs = s_axis_tready;
        @(posedge clk); #1;
        if (hs) break;
        waits++;
        if (waits > 1000) begin
          check("hs_timeout", 32'(waits), 32'd0);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
      if (expect_mode == 2) check("drop_ready", 32'(waits), 32'd0);
      if (expect_mode == 1 && !m_mode) begin
        check("no_bubble", 32'(waits), 32'd0);
        check("lat1_valid", 32'(m_axis_tvalid), 32'd1);
        check("lat1_beat", 32'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
              32'({s_axis_tlast, s_axis_tkeep, s_axis_tdata}));
      end
    end
    s_axis_tvalid       = 1'b0;
    s_axis_tlast        = 1'b0;
    fifo_is_almost_full = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    s_axis_tvalid = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic          de;
    logic          flag;
    logic [DW-1:0] data;
    logic          exp_pass;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{de: 1'b0, flag: 1'b0, data: 8'hA1, exp_pass: 1'b1};
    tbl[1] = '{de: 1'b0, flag: 1'b1, data: 8'hB2, exp_pass: 1'b1};
    tbl[2] = '{de: 1'b1, flag: 1'b0, data: 8'hC3, exp_pass: 1'b1};
    tbl[3] = '{de: 1'b1, flag: 1'b1, data: 8'hD4, exp_pass: 1'b0};
    tbl[4] = '{de: 1'b1, flag: 1'b1, data: 8'hE5, exp_pass: 1'b0};
    tbl[5] = '{de: 1'b1, flag: 1'b0, data: 8'hF6, exp_pass: 1'b1};
    tbl[6] = '{de: 1'b0, flag: 1'b1, data: 8'h07, exp_pass: 1'b1};
    tbl[7] = '{de: 1'b1, flag: 1'b1, data: 8'h18, exp_pass: 1'b0};

    // reset
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_axis_tvalid), 32'd0);
    check("rst_data", 32'(m_axis_tdata), 32'd0);
    check("rst_keep", 32'(m_axis_tkeep), 32'd0);
    check("rst_last", 32'(m_axis_tlast), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;
    @(posedge clk); #1;

    // single-beat frame table
    for (int v = 0; v < 8; v++) begin
      drop_enable         = tbl[v].de;
      fifo_is_almost_full = tbl[v].flag;
      s_axis_tdata        = tbl[v].data;
      s_axis_tkeep        = '1;
      s_axis_tlast        = 1'b1;
      s_axis_tvalid       = 1'b1;
      @(negedge clk);
      check("tbl_ready", 32'(s_axis_tready), 32'd1);
      @(posedge clk); #1;
      s_axis_tvalid       = 1'b0;
      fifo_is_almost_full = 1'b0;
      check("tbl_valid", 32'(m_axis_tvalid), 32'(tbl[v].exp_pass));
      if (tbl[v].exp_pass) check("tbl_data", 32'({m_axis_tlast, m_axis_tdata}), 32'({1'b1, tbl[v].data}));
      check("tbl_state", 32'(dbg_state), 32'(ST_IDLE));
    end
    drain();

    // 64-beat frame, nothing dropped, full rate
    send_frame(64, -1, 1'b1, 0, 1'b0, 1);
    // one-cycle flag pulse in the middle of a passing frame
    send_frame(64, 30, 1'b1, 0, 1'b0, 1);
    send_frame(64, -1, 1'b1, 0, 1'b0, 1);
    drain();

    // three back-to-back frames, flag at the first beat of the second
    send_frame(16, -1, 1'b1, 0, 1'b0, 1);
    send_frame(16, 0, 1'b1, 0, 1'b0, 2);
    check("drop_no_out", 32'(m_axis_tvalid), 32'd0);
    send_frame(16, -1, 1'b1, 0, 1'b0, 1);
    drain();

    // same with dropping disabled: all three pass
    send_frame(16, -1, 1'b0, 0, 1'b0, 1);
    send_frame(16, 0, 1'b0, 0, 1'b0, 1);
    send_frame(16, -1, 1'b0, 0, 1'b0, 1);
    drain();

    // single-beat dropped frame followed by a passing one
    send_frame(1, 0, 1'b1, 0, 1'b0, 2);
    check("single_drop_state", 32'(dbg_state), 32'(ST_IDLE));
    check("single_drop_out", 32'(m_axis_tvalid), 32'd0);
    send_frame(5, -1, 1'b1, 0, 1'b0, 1);
    drain();

    // backpressure on the output in pass mode
    m_mode = 1'b1;
    send_frame(32, -1, 1'b0, 0, 1'b0, 0);
    send_frame(32, 5, 1'b1, 0, 1'b0, 0);
    m_mode = 1'b0;
    drain();

    // reset in the middle of a frame
    drop_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata  = DW'($urandom);
      s_axis_tkeep  = '1;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_valid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rstn = 1'b1;
    send_frame(6, -1, 1'b1, 0, 1'b0, 1);
    drain();

    // randomized traffic against the reference model
    m_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_frame($urandom_range(1, 20), ($urandom_range(0, 1) != 0) ? 0 : -1,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 30 : 0, 1'b1, 0);
    end
    m_mode = 1'b0;
    @(posedge clk); #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
